// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- RV32 integer register file with write-back scoreboard.
//
// Receives the write-back port and keeps x0 hardwired to zero. Two read
// ports return data combinationally and bypass a same-cycle write. A busy
// bit per register tracks in-flight writers so that decode can stall on
// read-after-write (hazard1/hazard2) and write-after-write (waw) hazards.
//
// Parameters:
//   NREGS      number of architectural registers (index width is 5)
//   RESET_VAL  value loaded into x1..x31 on reset
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   w_en, waddr, wdata   write-back port; waddr[5]=1 means "no destination"
//   raddr1/2, rdata1/2   combinational read ports with write bypass
//   issue_en, issue_dest decode issue; issue_dest encoded like waddr
//   hazard1/2            read operand pending and not bypassable this cycle
//   waw                  issue_dest is already busy
//   stall                hazard1 | hazard2 | waw
//   pend_cnt             number of busy registers (popcount of busy)
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int unsigned NREGS     = 32,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_en,
  input  logic [5:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        issue_en,
  input  logic [5:0]  issue_dest,
  output logic        hazard1,
  output logic        hazard2,
  output logic        waw,
  output logic        stall,
  output logic [5:0]  pend_cnt
);

  // True when a 6-bit destination names a real, writable register.
  function automatic logic is_real_dest(input logic [5:0] dest);
    return (dest[5] == 1'b0) && (dest[4:0] != 5'd0);
  endfunction

  // Architectural state.
  logic [31:0]      regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [5:0]       pend_cnt_r;

  // Decoded control.
  logic [4:0]       w_idx_s;
  logic [4:0]       i_idx_s;
  logic             wr_valid_s;
  logic             issue_real_s;
  logic             byp1_s;
  logic             byp2_s;
  logic             hazard1_s;
  logic             hazard2_s;
  logic             waw_s;
  logic             stall_s;
  logic             set_s;
  logic             clr_s;
  logic             clr_eff_s;
  logic [31:0]      rdata1_s;
  logic [31:0]      rdata2_s;
  logic [NREGS-1:0] busy_next_s;
  logic [5:0]       pend_next_s;

  assign w_idx_s      = waddr[4:0];
  assign i_idx_s      = issue_dest[4:0];
  assign wr_valid_s   = w_en & is_real_dest(waddr);
  assign issue_real_s = issue_en & is_real_dest(issue_dest);

  // A valid write to the read index this cycle forwards its data and also
  // resolves any pending hazard on that register.
  assign byp1_s = wr_valid_s & (w_idx_s == raddr1);
  assign byp2_s = wr_valid_s & (w_idx_s == raddr2);

  // Read port 1: x0 reads zero, then bypass, then the array.
  always_comb begin
    rdata1_s = 32'h0000_0000;
    if (raddr1 == 5'd0) begin
      rdata1_s = 32'h0000_0000;
    end else if (byp1_s) begin
      rdata1_s = wdata;
    end else begin
      rdata1_s = regs_r[raddr1];
    end
  end

  // Read port 2: x0 reads zero, then bypass, then the array.
  always_comb begin
    rdata2_s = 32'h0000_0000;
    if (raddr2 == 5'd0) begin
      rdata2_s = 32'h0000_0000;
    end else if (byp2_s) begin
      rdata2_s = wdata;
    end else begin
      rdata2_s = regs_r[raddr2];
    end
  end

  // Hazard detection. busy_r[0] is held at zero, but x0 is excluded
  // explicitly so a hazard can never be raised for it.
  always_comb begin
    hazard1_s = (raddr1 != 5'd0) & busy_r[raddr1] & ~byp1_s;
    hazard2_s = (raddr2 != 5'd0) & busy_r[raddr2] & ~byp2_s;
    // A write retiring the same register does not cancel waw; decode retries.
    waw_s     = issue_real_s & busy_r[i_idx_s];
    stall_s   = hazard1_s | hazard2_s | waw_s;
  end

  // Scoreboard set/clear qualification. Clearing a register that is not
  // busy is a no-op, which is what keeps pend_cnt from underflowing.
  always_comb begin
    set_s     = issue_real_s & ~stall_s;
    clr_s     = wr_valid_s & busy_r[w_idx_s];
    clr_eff_s = clr_s & ~(set_s & (i_idx_s == w_idx_s));
  end

  // Next busy vector: clear first, then set, so set wins on a collision.
  always_comb begin
    busy_next_s = busy_r;
    if (clr_s) begin
      busy_next_s[w_idx_s] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (set_s) begin
      busy_next_s[i_idx_s] = 1'b1;
    end else begin
      busy_next_s[i_idx_s] = busy_next_s[i_idx_s];
    end
    busy_next_s[0] = 1'b0;
  end

  // Next pending count tracks the busy vector by +1/-1 increments.
  always_comb begin
    pend_next_s = pend_cnt_r;
    case ({set_s, clr_eff_s})
      2'b10:   pend_next_s = pend_cnt_r + 6'd1;
      2'b01:   pend_next_s = pend_cnt_r - 6'd1;
      default: pend_next_s = pend_cnt_r;
    endcase
  end

  // State update: reset overrides any write or issue in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_r[i] <= (i == 0) ? 32'h0000_0000 : RESET_VAL;
      end
      busy_r     <= {NREGS{1'b0}};
      pend_cnt_r <= 6'd0;
    end else begin
      if (wr_valid_s) begin
        regs_r[w_idx_s] <= wdata;
      end
      busy_r     <= busy_next_s;
      pend_cnt_r <= pend_next_s;
    end
  end

  assign rdata1   = rdata1_s;
  assign rdata2   = rdata2_s;
  assign hazard1  = hazard1_s;
  assign hazard2  = hazard2_s;
  assign waw      = waw_s;
  assign stall    = stall_s;
  assign pend_cnt = pend_cnt_r;

  reg_file_chk #(
    .NREGS (NREGS)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy_r),
    .pend_cnt (pend_cnt_r)
  );

endmodule

// ---------------------------------------------------------------------------
// reg_file_chk -- scoreboard consistency properties.
//
// Ports:
//   clk, reset  clock and synchronous reset of the register file
//   busy        busy vector of the scoreboard
//   pend_cnt    pending-writer count
// ---------------------------------------------------------------------------
module reg_file_chk #(
  parameter int unsigned NREGS = 32
) (
  input logic             clk,
  input logic             reset,
  input logic [NREGS-1:0] busy,
  input logic [5:0]       pend_cnt
);

  // The pending count is always the popcount of the busy vector.
  a_pend_popcount: assert property (@(posedge clk) disable iff (reset)
    ({26'd0, pend_cnt} == 32'($countones(busy))));

  // x0 never becomes busy.
  a_x0_never_busy: assert property (@(posedge clk) disable iff (reset)
    (busy[0] == 1'b0));

  // The count never leaves its legal range.
  a_pend_range: assert property (@(posedge clk) disable iff (reset)
    (pend_cnt <= 6'd31));

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- scoreboard bench for reg_file.
// Each directed vector is applied for one cycle and its hand-computed
// expected outputs are pushed into a queue; a monitor on the falling edge
// pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        w_en;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        issue_en;
  logic [5:0]  issue_dest;
  logic        hazard1;
  logic        hazard2;
  logic        waw;
  logic        stall;
  logic [5:0]  pend_cnt;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        h1;
    logic        h2;
    logic        waw;
    logic        stall;
    logic [5:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  logic vec_valid;
  int   n_vec;
  int   n_miss;

  reg_file #(
    .NREGS     (32),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .w_en       (w_en),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .waw        (waw),
    .stall      (stall),
    .pend_cnt   (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the DUT outputs of every applied vector mid-cycle.
  always @(negedge clk) begin
    if (vec_valid) begin
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_miss = n_miss + 1;
        $display("FAIL scoreboard_empty: got an applied vector, required a queued expectation");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rdata1 !== e.rd1 || rdata2 !== e.rd2 || hazard1 !== e.h1 ||
            hazard2 !== e.h2 || waw !== e.waw || stall !== e.stall ||
            pend_cnt !== e.pend) begin
          n_miss = n_miss + 1;
          $display("FAIL %s: got rd1=%h rd2=%h h1=%b h2=%b waw=%b stall=%b pend=%0d, required rd1=%h rd2=%h h1=%b h2=%b waw=%b stall=%b pend=%0d",
                   e.name, rdata1, rdata2, hazard1, hazard2, waw, stall, pend_cnt,
                   e.rd1, e.rd2, e.h1, e.h2, e.waw, e.stall, e.pend);
        end
      end
    end
  end

  // Apply one cycle of stimulus and queue its expected outputs.
  task automatic vec(input string nm, input logic rst, input logic we,
                     input logic [5:0] wa, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic ie, input logic [5:0] id,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic eh1, input logic eh2, input logic ew,
                     input logic es, input logic [5:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    w_en       = we;
    waddr      = wa;
    wdata      = wd;
    raddr1     = r1;
    raddr2     = r2;
    issue_en   = ie;
    issue_dest = id;
    e.name  = nm;
    e.rd1   = e1;
    e.rd2   = e2;
    e.h1    = eh1;
    e.h2    = eh2;
    e.waw   = ew;
    e.stall = es;
    e.pend  = ep;
    exp_q.push_back(e);
    vec_valid = 1'b1;
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    vec_valid  = 1'b0;
    reset      = 1'b1;
    w_en       = 1'b0;
    waddr      = 6'd0;
    wdata      = 32'h0;
    raddr1     = 5'd0;
    raddr2     = 5'd0;
    issue_en   = 1'b0;
    issue_dest = 6'd0;
    repeat (2) @(posedge clk);

    // Reset state: every register reads zero, nothing pending.
    for (int i = 0; i < 32; i += 2) begin
      vec("reset_read", 1'b0, 1'b0, 6'd0, 32'h0, 5'(i), 5'(i + 1), 1'b0, 6'd0,
          32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    end

    // Bypass, then array read, then x0 write dropped.
    vec("x5_bypass", 1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 1'b0, 6'd0,
        32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("x5_array", 1'b0, 1'b0, 6'd0, 32'h0, 5'd5, 5'd5, 1'b0, 6'd0,
        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("x0_write", 1'b0, 1'b1, 6'd0, 32'h0000_1234, 5'd0, 5'd5, 1'b0, 6'd0,
        32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("x0_after", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd0, 1'b0, 6'd0,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("x31_bypass", 1'b0, 1'b1, 6'd31, 32'hA5A5_5A5A, 5'd0, 5'd31, 1'b0, 6'd0,
        32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("x31_array", 1'b0, 1'b0, 6'd0, 32'h0, 5'd31, 5'd0, 1'b0, 6'd0,
        32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // RAW on x7: issue, hazard, cleared by same-cycle write, count drops.
    vec("issue_x7", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd0, 1'b1, 6'd7,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("x7_hazard", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd7, 1'b0, 6'd0,
        32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd1);
    vec("x7_wb_bypass", 1'b0, 1'b1, 6'd7, 32'h0000_0042, 5'd0, 5'd7, 1'b0, 6'd0,
        32'h0, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);
    vec("x7_retired", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd7, 1'b0, 6'd0,
        32'h0, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // WAW on x9 while x9 retires: waw holds, no set; retry succeeds.
    vec("issue_x9", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd0, 1'b1, 6'd9,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("x9_waw_retire", 1'b0, 1'b1, 6'd9, 32'h0000_0099, 5'd9, 5'd0, 1'b1, 6'd9,
        32'h0000_0099, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1);
    vec("x9_retry", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd0, 1'b1, 6'd9,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("x9_busy", 1'b0, 1'b0, 6'd0, 32'h0, 5'd9, 5'd0, 1'b0, 6'd0,
        32'h0000_0099, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1);
    vec("x9_wb", 1'b0, 1'b1, 6'd9, 32'h0000_0100, 5'd9, 5'd0, 1'b0, 6'd0,
        32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);

    // No-destination issue and write: no busy, array or count change.
    vec("issue_x5", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd0, 1'b1, 6'd5,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("nodest", 1'b0, 1'b1, 6'b100101, 32'hFFFF_FFFF, 5'd3, 5'd0, 1'b1, 6'b100011,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);
    vec("nodest_after", 1'b0, 1'b0, 6'd0, 32'h0, 5'd5, 5'd3, 1'b0, 6'd0,
        32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1);
    vec("x5_wb", 1'b0, 1'b1, 6'd5, 32'h0000_0055, 5'd5, 5'd0, 1'b0, 6'd0,
        32'h0000_0055, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);

    // Three in flight, then reset with a write to one of them.
    vec("issue_x10", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd0, 1'b1, 6'd10,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("issue_x11", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd0, 1'b1, 6'd11,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);
    vec("issue_x12", 1'b0, 1'b0, 6'd0, 32'h0, 5'd0, 5'd0, 1'b1, 6'd12,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2);
    vec("reset_mid", 1'b1, 1'b1, 6'd11, 32'h0000_0BAD, 5'd11, 5'd12, 1'b0, 6'd0,
        32'h0000_0BAD, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd3);
    vec("post_reset", 1'b0, 1'b0, 6'd0, 32'h0, 5'd11, 5'd12, 1'b0, 6'd0,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("post_reset_regs", 1'b0, 1'b0, 6'd0, 32'h0, 5'd5, 5'd7, 1'b0, 6'd0,
        32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("late_wb", 1'b0, 1'b1, 6'd10, 32'h0000_0007, 5'd10, 5'd0, 1'b0, 6'd0,
        32'h0000_0007, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vec("late_wb_after", 1'b0, 1'b0, 6'd0, 32'h0, 5'd10, 5'd31, 1'b0, 6'd0,
        32'h0000_0007, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    @(posedge clk);
    #1;
    vec_valid = 1'b0;
    w_en      = 1'b0;
    issue_en  = 1'b0;
    @(posedge clk);

    n_vec = n_vec + 1;
    if (exp_q.size() != 0) begin
      n_miss = n_miss + 1;
      $display("FAIL scoreboard_drain: got %0d unchecked expectations, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
